mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 67 ++++++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundled handshakes around mem_arbiter: two requester ports, the shared memory
// request channel and the memory response channel.
interface mem_arbiter_if #(
    parameter int p_opaq_bits = 8
);
    logic                   req0_val;
    logic                   req0_rdy;
    logic                   req0_op;
    logic [p_opaq_bits-1:0] req0_opaque;
    logic [31:0]            req0_addr;
    logic [31:0]            req0_data;

    logic                   req1_val;
    logic                   req1_rdy;
    logic                   req1_op;
    logic [p_opaq_bits-1:0] req1_opaque;
    logic [31:0]            req1_addr;
    logic [31:0]            req1_data;

    logic                   mem_req_val;
    logic                   mem_req_rdy;
    logic                   mem_req_op;
    logic [p_opaq_bits:0]   mem_req_opaque;
    logic [31:0]            mem_req_addr;
    logic [31:0]            mem_req_data;

    logic                   mem_resp_val;
    logic                   mem_resp_rdy;
    logic [p_opaq_bits:0]   mem_resp_opaque;
    logic [31:0]            mem_resp_data;

    logic                   resp0_val;
    logic                   resp0_rdy;
    logic [p_opaq_bits-1:0] resp0_opaque;
    logic [31:0]            resp0_data;

    logic                   resp1_val;
    logic                   resp1_rdy;
    logic [p_opaq_bits-1:0] resp1_opaque;
    logic [31:0]            resp1_data;

    // Arbiter-side view.
    modport slave (
        input  req0_val, req0_op, req0_opaque, req0_addr, req0_data,
        input  req1_val, req1_op, req1_opaque, req1_addr, req1_data,
        input  mem_req_rdy, mem_resp_val, mem_resp_opaque, mem_resp_data,
        input  resp0_rdy, resp1_rdy,
        output req0_rdy, req1_rdy,
        output mem_req_val, mem_req_op, mem_req_opaque, mem_req_addr, mem_req_data,
        output mem_resp_rdy,
        output resp0_val, resp0_opaque, resp0_data,
        output resp1_val, resp1_opaque, resp1_data
    );

    // Environment-side view (requesters plus memory).
    modport master (
        output req0_val, req0_op, req0_opaque, req0_addr, req0_data,
        output req1_val, req1_op, req1_opaque, req1_addr, req1_data,
        output mem_req_rdy, mem_resp_val, mem_resp_opaque, mem_resp_data,
        output resp0_rdy, resp1_rdy,
        input  req0_rdy, req1_rdy,
        input  mem_req_val, mem_req_op, mem_req_opaque, mem_req_addr, mem_req_data,
        input  mem_resp_rdy,
        input  resp0_val, resp0_opaque, resp0_data,
        input  resp1_val, resp1_opaque, resp1_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter onto one memory port, with a per-requester
// outstanding-request limit and zero-latency response routing by tag MSB.
module mem_arbiter #(
    parameter int p_opaq_bits       = 8,
    parameter int p_max_outstanding = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int                 c_cnt_w     = $clog2(p_max_outstanding + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max   = c_cnt_w'(p_max_outstanding);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero  = c_cnt_w'(0);
    localparam logic [0:0]         c_st_idle   = 1'b0;
    localparam logic [0:0]         c_st_locked = 1'b1;

    logic [0:0]         state_r;
    logic               lock_id_r;
    logic               prio_r;
    logic [c_cnt_w-1:0] cnt0_r;
    logic [c_cnt_w-1:0] cnt1_r;

    logic elig0_s, elig1_s;
    logic grant_val_s, grant_id_s;
    logic req_fire_s, resp_fire_s, resp_id_s;

    // Both fires in the same cycle cancel; a lone response never drives a counter below zero.
    function automatic logic [c_cnt_w-1:0] cnt_next(input logic [c_cnt_w-1:0] cnt,
                                                    input logic inc, input logic dec);
        case ({inc, dec})
            2'b10:   cnt_next = (cnt == c_cnt_max)  ? cnt : cnt + c_cnt_one;
            2'b01:   cnt_next = (cnt == c_cnt_zero) ? cnt : cnt - c_cnt_one;
            default: cnt_next = cnt;
        endcase
    endfunction

    assign elig0_s     = bus.req0_val && (cnt0_r < c_cnt_max);
    assign elig1_s     = bus.req1_val && (cnt1_r < c_cnt_max);
    assign req_fire_s  = grant_val_s && bus.mem_req_rdy;
    assign resp_id_s   = bus.mem_resp_opaque[p_opaq_bits];
    assign resp_fire_s = bus.mem_resp_val && bus.mem_resp_rdy;

    // Grant selection: an offered-but-unaccepted grant is held, otherwise eligibility and priority.
    always_comb begin
        grant_val_s = 1'b0;
        grant_id_s  = 1'b0;
        if (rst) begin
            grant_val_s = 1'b0;
            grant_id_s  = 1'b0;
        end else if (state_r == c_st_locked) begin
            grant_val_s = 1'b1;
            grant_id_s  = lock_id_r;
        end else if (elig0_s && elig1_s) begin
            grant_val_s = 1'b1;
            grant_id_s  = prio_r;
        end else if (elig0_s) begin
            grant_val_s = 1'b1;
            grant_id_s  = 1'b0;
        end else if (elig1_s) begin
            grant_val_s = 1'b1;
            grant_id_s  = 1'b1;
        end else begin
            grant_val_s = 1'b0;
            grant_id_s  = 1'b0;
        end
    end

    // Forward the granted requester's fields and ready.
    always_comb begin
        bus.mem_req_val = grant_val_s;
        bus.req0_rdy    = grant_val_s && !grant_id_s && bus.mem_req_rdy;
        bus.req1_rdy    = grant_val_s &&  grant_id_s && bus.mem_req_rdy;
        bus.mem_req_op     = bus.req0_op;
        bus.mem_req_addr   = bus.req0_addr;
        bus.mem_req_data   = bus.req0_data;
        bus.mem_req_opaque = {1'b0, bus.req0_opaque};
        if (grant_id_s) begin
            bus.mem_req_op     = bus.req1_op;
            bus.mem_req_addr   = bus.req1_addr;
            bus.mem_req_data   = bus.req1_data;
            bus.mem_req_opaque = {1'b1, bus.req1_opaque};
        end else begin
            bus.mem_req_op     = bus.req0_op;
            bus.mem_req_addr   = bus.req0_addr;
            bus.mem_req_data   = bus.req0_data;
            bus.mem_req_opaque = {1'b0, bus.req0_opaque};
        end
    end

    // Route responses by tag MSB; the ready seen by memory follows the addressed requester.
    always_comb begin
        bus.resp0_val    = !rst && bus.mem_resp_val && !resp_id_s;
        bus.resp1_val    = !rst && bus.mem_resp_val &&  resp_id_s;
        bus.resp0_opaque = bus.mem_resp_opaque[p_opaq_bits-1:0];
        bus.resp1_opaque = bus.mem_resp_opaque[p_opaq_bits-1:0];
        bus.resp0_data   = bus.mem_resp_data;
        bus.resp1_data   = bus.mem_resp_data;
        if (rst) begin
            bus.mem_resp_rdy = 1'b0;
        end else if (resp_id_s) begin
            bus.mem_resp_rdy = bus.resp1_rdy;
        end else begin
            bus.mem_resp_rdy = bus.resp0_rdy;
        end
    end

    // Lock/priority state and outstanding counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= c_st_idle;
            lock_id_r <= 1'b0;
            prio_r    <= 1'b0;
            cnt0_r    <= c_cnt_zero;
            cnt1_r    <= c_cnt_zero;
        end else begin
            if (req_fire_s) begin
                state_r <= c_st_idle;
                prio_r  <= ~grant_id_s;
            end else if (grant_val_s) begin
                state_r   <= c_st_locked;
                lock_id_r <= grant_id_s;
            end else begin
                state_r <= c_st_idle;
            end
            cnt0_r <= cnt_next(cnt0_r, req_fire_s && !grant_id_s, resp_fire_s && !resp_id_s);
            cnt1_r <= cnt_next(cnt1_r, req_fire_s &&  grant_id_s, resp_fire_s &&  resp_id_s);
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboarded memory requests plus
// per-scenario checks of grant, lock, limit, response routing and reset.
module tb_mem_arbiter;
    localparam int c_opq = 8;
    localparam int c_max = 4;

    typedef struct packed {
        logic             id;
        logic             op;
        logic [31:0]      addr;
        logic [31:0]      data;
        logic [c_opq-1:0] opq;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    mem_arbiter_if #(.p_opaq_bits(c_opq)) bus ();

    mem_arbiter #(.p_opaq_bits(c_opq), .p_max_outstanding(c_max)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation timeout");
    end

    // Scoreboard: every accepted memory request must match the oldest expected one.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.mem_req_val && bus.mem_req_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: actual addr=%h opq=%h required no request",
                         bus.mem_req_addr, bus.mem_req_opaque);
            end else begin
                e = exp_q.pop_front();
                if ({bus.mem_req_opaque, bus.mem_req_op, bus.mem_req_addr, bus.mem_req_data}
                    !== {e.id, e.opq, e.op, e.addr, e.data}) begin
                    errors++;
                    $display("FAIL sb_req: actual opq=%h op=%b addr=%h data=%h required opq=%h op=%b addr=%h data=%h",
                             bus.mem_req_opaque, bus.mem_req_op, bus.mem_req_addr, bus.mem_req_data,
                             {e.id, e.opq}, e.op, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0_val = 1'b0; bus.req0_op = 1'b0; bus.req0_opaque = 8'h00;
        bus.req0_addr = 32'h0; bus.req0_data = 32'h0;
        bus.req1_val = 1'b0; bus.req1_op = 1'b0; bus.req1_opaque = 8'h00;
        bus.req1_addr = 32'h0; bus.req1_data = 32'h0;
        bus.mem_req_rdy = 1'b0; bus.mem_resp_val = 1'b0;
        bus.mem_resp_opaque = 9'h000; bus.mem_resp_data = 32'h0;
        bus.resp0_rdy = 1'b0; bus.resp1_rdy = 1'b0;
    endtask

    task automatic set_req(input int k, input logic val, input logic op,
                           input logic [31:0] addr, input logic [31:0] data, input logic [7:0] opq);
        if (k == 0) begin
            bus.req0_val = val; bus.req0_op = op; bus.req0_addr = addr;
            bus.req0_data = data; bus.req0_opaque = opq;
        end else begin
            bus.req1_val = val; bus.req1_op = op; bus.req1_addr = addr;
            bus.req1_data = data; bus.req1_opaque = opq;
        end
    endtask

    task automatic push_exp(input logic id, input logic op, input logic [31:0] addr,
                            input logic [31:0] data, input logic [7:0] opq);
        exp_t e;
        e.id = id; e.op = op; e.addr = addr; e.data = data; e.opq = opq;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.req0_val = 1'b1; bus.req1_val = 1'b1; bus.mem_req_rdy = 1'b1;
        bus.mem_resp_val = 1'b1; bus.mem_resp_opaque = 9'h100;
        bus.resp0_rdy = 1'b1; bus.resp1_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.mem_req_val, bus.mem_resp_rdy, bus.req0_rdy, bus.req1_rdy, bus.resp0_val, bus.resp1_val} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_outputs: actual=%b required=000000",
                     {bus.mem_req_val, bus.mem_resp_rdy, bus.req0_rdy, bus.req1_rdy, bus.resp0_val, bus.resp1_val});
        end
        tick();
        checks++;
        if ({dut.state_r, dut.prio_r, dut.cnt0_r, dut.cnt1_r} !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: actual=%h required=00", {dut.state_r, dut.prio_r, dut.cnt0_r, dut.cnt1_r});
        end
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_alternate();
        logic [2:0] want;
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'h1000_0000, 32'h0000_0000, 8'h11);
        set_req(1, 1'b1, 1'b1, 32'h2000_0000, 32'hCAFE_0001, 8'h22);
        bus.mem_req_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) push_exp(1'b0, 1'b0, 32'h1000_0000, 32'h0000_0000, 8'h11);
            else            push_exp(1'b1, 1'b1, 32'h2000_0000, 32'hCAFE_0001, 8'h22);
        end
        for (int i = 0; i < 6; i++) begin
            want = (i % 2 == 0) ? 3'b001 : 3'b110;
            @(negedge clk);
            checks++;
            if ({bus.mem_req_opaque[c_opq], bus.req1_rdy, bus.req0_rdy} !== want) begin
                errors++;
                $display("FAIL alternate_%0d: actual {msb,rdy1,rdy0}=%b required=%b",
                         i, {bus.mem_req_opaque[c_opq], bus.req1_rdy, bus.req0_rdy}, want);
            end
            tick();
        end
        clear_inputs();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL alternate_drain: actual pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_lock_stall();
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'h0000_0F00, 32'h0, 8'h01);
        bus.mem_req_rdy = 1'b1;
        push_exp(1'b0, 1'b0, 32'h0000_0F00, 32'h0, 8'h01);
        tick();
        set_req(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 8'h02);
        bus.mem_req_rdy = 1'b0;
        push_exp(1'b0, 1'b0, 32'h0000_1000, 32'h0, 8'h02);
        push_exp(1'b1, 1'b0, 32'h0000_2000, 32'h0, 8'h03);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) set_req(1, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 8'h03);
            @(negedge clk);
            checks++;
            if ({bus.mem_req_val, bus.mem_req_opaque[c_opq], bus.mem_req_addr, bus.req0_rdy, bus.req1_rdy}
                !== {1'b1, 1'b0, 32'h0000_1000, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL lock_hold_%0d: actual val=%b id=%b addr=%h rdy0=%b rdy1=%b required val=1 id=0 addr=00001000 rdy0=0 rdy1=0",
                         i, bus.mem_req_val, bus.mem_req_opaque[c_opq], bus.mem_req_addr, bus.req0_rdy, bus.req1_rdy);
            end
            tick();
        end
        bus.mem_req_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.req0_rdy, bus.req1_rdy, bus.mem_req_addr} !== {1'b1, 1'b0, 32'h0000_1000}) begin
            errors++;
            $display("FAIL lock_fire: actual rdy0=%b rdy1=%b addr=%h required rdy0=1 rdy1=0 addr=00001000",
                     bus.req0_rdy, bus.req1_rdy, bus.mem_req_addr);
        end
        tick();
        bus.req0_val = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.req1_rdy, bus.mem_req_opaque[c_opq], bus.mem_req_addr} !== {1'b1, 1'b1, 32'h0000_2000}) begin
            errors++;
            $display("FAIL lock_next: actual rdy1=%b id=%b addr=%h required rdy1=1 id=1 addr=00002000",
                     bus.req1_rdy, bus.mem_req_opaque[c_opq], bus.mem_req_addr);
        end
        tick();
        clear_inputs();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL lock_drain: actual pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_limit();
        do_reset();
        bus.mem_req_rdy = 1'b1;
        for (int i = 0; i < c_max; i++) begin
            set_req(0, 1'b1, 1'b0, 32'h0000_3000 + 32'(4 * i), 32'(i), 8'(8'h30 + i));
            push_exp(1'b0, 1'b0, 32'h0000_3000 + 32'(4 * i), 32'(i), 8'(8'h30 + i));
            @(negedge clk);
            checks++;
            if (bus.req0_rdy !== 1'b1) begin
                errors++;
                $display("FAIL limit_issue_%0d: actual rdy0=%b required=1", i, bus.req0_rdy);
            end
            tick();
        end
        set_req(0, 1'b1, 1'b0, 32'h0000_3010, 32'h4, 8'h34);
        set_req(1, 1'b1, 1'b1, 32'h0000_4000, 32'h5, 8'h40);
        push_exp(1'b1, 1'b1, 32'h0000_4000, 32'h5, 8'h40);
        @(negedge clk);
        checks++;
        if ({bus.req0_rdy, bus.req1_rdy, bus.mem_req_opaque[c_opq]} !== 3'b011) begin
            errors++;
            $display("FAIL limit_other_served: actual {rdy0,rdy1,id}=%b required=011",
                     {bus.req0_rdy, bus.req1_rdy, bus.mem_req_opaque[c_opq]});
        end
        tick();
        bus.req1_val = 1'b0;
        bus.mem_resp_val = 1'b1; bus.mem_resp_opaque = {1'b0, 8'h30}; bus.resp0_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.mem_req_val, bus.req0_rdy, bus.resp0_val, bus.mem_resp_rdy} !== 4'b0011) begin
            errors++;
            $display("FAIL limit_blocked: actual {val,rdy0,resp0_val,resp_rdy}=%b required=0011",
                     {bus.mem_req_val, bus.req0_rdy, bus.resp0_val, bus.mem_resp_rdy});
        end
        tick();
        bus.mem_resp_val = 1'b0;
        push_exp(1'b0, 1'b0, 32'h0000_3010, 32'h4, 8'h34);
        @(negedge clk);
        checks++;
        if ({bus.req0_rdy, bus.mem_req_addr} !== {1'b1, 32'h0000_3010}) begin
            errors++;
            $display("FAIL limit_release: actual rdy0=%b addr=%h required rdy0=1 addr=00003010",
                     bus.req0_rdy, bus.mem_req_addr);
        end
        tick();
        clear_inputs();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL limit_drain: actual pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_resp_route();
        do_reset();
        bus.mem_resp_val = 1'b1; bus.mem_resp_opaque = 9'h15A; bus.mem_resp_data = 32'hDEAD_BEEF;
        bus.resp0_rdy = 1'b1; bus.resp1_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.resp1_val, bus.resp0_val, bus.mem_resp_rdy, bus.resp1_opaque, bus.resp1_data}
            !== {3'b101, 8'h5A, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL resp1_route: actual v1=%b v0=%b rdy=%b opq=%h data=%h required v1=1 v0=0 rdy=1 opq=5a data=deadbeef",
                     bus.resp1_val, bus.resp0_val, bus.mem_resp_rdy, bus.resp1_opaque, bus.resp1_data);
        end
        bus.resp1_rdy = 1'b0;
        #1;
        checks++;
        if ({bus.resp1_val, bus.mem_resp_rdy} !== 2'b10) begin
            errors++;
            $display("FAIL resp1_stall: actual {v1,rdy}=%b required=10", {bus.resp1_val, bus.mem_resp_rdy});
        end
        tick();
        bus.resp1_rdy = 1'b1; bus.resp0_rdy = 1'b0;
        bus.mem_resp_opaque = 9'h0A5; bus.mem_resp_data = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if ({bus.resp0_val, bus.resp1_val, bus.mem_resp_rdy, bus.resp0_opaque, bus.resp0_data}
            !== {3'b100, 8'hA5, 32'h1234_5678}) begin
            errors++;
            $display("FAIL resp0_route: actual v0=%b v1=%b rdy=%b opq=%h data=%h required v0=1 v1=0 rdy=0 opq=a5 data=12345678",
                     bus.resp0_val, bus.resp1_val, bus.mem_resp_rdy, bus.resp0_opaque, bus.resp0_data);
        end
        bus.resp0_rdy = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (dut.cnt0_r !== 3'd0) begin
            errors++;
            $display("FAIL resp_saturate: actual cnt0=%0d required=0", dut.cnt0_r);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        bus.mem_req_rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_req(0, 1'b1, 1'b1, 32'h0000_7000 + 32'(i), 32'h0000_00A0 + 32'(i), 8'(8'h70 + i));
            push_exp(1'b0, 1'b1, 32'h0000_7000 + 32'(i), 32'h0000_00A0 + 32'(i), 8'(8'h70 + i));
            tick();
        end
        checks++;
        if (dut.cnt0_r !== 3'd2) begin
            errors++;
            $display("FAIL same_pre: actual cnt0=%0d required=2", dut.cnt0_r);
        end
        set_req(0, 1'b1, 1'b0, 32'h0000_7100, 32'h0, 8'h72);
        push_exp(1'b0, 1'b0, 32'h0000_7100, 32'h0, 8'h72);
        bus.mem_resp_val = 1'b1; bus.mem_resp_opaque = {1'b0, 8'h70}; bus.resp0_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.req0_rdy, bus.mem_resp_rdy} !== 2'b11) begin
            errors++;
            $display("FAIL same_fires: actual {rdy0,resp_rdy}=%b required=11", {bus.req0_rdy, bus.mem_resp_rdy});
        end
        tick();
        clear_inputs();
        checks++;
        if (dut.cnt0_r !== 3'd2) begin
            errors++;
            $display("FAIL same_cnt: actual cnt0=%0d required=2", dut.cnt0_r);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL same_drain: actual pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.mem_req_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req(1, 1'b1, 1'b0, 32'h0000_5000 + 32'(i), 32'h0, 8'(8'h50 + i));
            push_exp(1'b1, 1'b0, 32'h0000_5000 + 32'(i), 32'h0, 8'(8'h50 + i));
            tick();
        end
        bus.req1_val = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h0000_5800, 32'h0, 8'h58);
        push_exp(1'b0, 1'b0, 32'h0000_5800, 32'h0, 8'h58);
        tick();
        bus.req0_val = 1'b0;
        set_req(1, 1'b1, 1'b0, 32'h0000_6000, 32'h0, 8'h60);
        bus.mem_req_rdy = 1'b0;
        tick();
        checks++;
        if ({dut.state_r, dut.lock_id_r, dut.prio_r, dut.cnt1_r} !== 6'b111011) begin
            errors++;
            $display("FAIL mid_pre: actual {st,lock,prio,cnt1}=%b required=111011",
                     {dut.state_r, dut.lock_id_r, dut.prio_r, dut.cnt1_r});
        end
        rst = 1'b1;
        bus.req0_val = 1'b1; bus.mem_req_rdy = 1'b1; bus.mem_resp_val = 1'b1;
        bus.mem_resp_opaque = 9'h100; bus.resp0_rdy = 1'b1; bus.resp1_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.mem_req_val, bus.mem_resp_rdy, bus.req0_rdy, bus.req1_rdy, bus.resp0_val, bus.resp1_val} !== 6'b000000) begin
            errors++;
            $display("FAIL mid_outputs: actual=%b required=000000",
                     {bus.mem_req_val, bus.mem_resp_rdy, bus.req0_rdy, bus.req1_rdy, bus.resp0_val, bus.resp1_val});
        end
        tick();
        checks++;
        if ({dut.state_r, dut.prio_r, dut.cnt0_r, dut.cnt1_r} !== 8'h00) begin
            errors++;
            $display("FAIL mid_state: actual=%h required=00", {dut.state_r, dut.prio_r, dut.cnt0_r, dut.cnt1_r});
        end
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (bus.mem_req_val !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_replay: actual val=%b required=0", bus.mem_req_val);
        end
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_drain: actual pending=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_alternate();
        test_lock_stall();
        test_limit();
        test_resp_route();
        test_same_cycle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
